// File: rtl/store_data_fwd_ctrl.sv
// Store-data forwarding control for the EXE-stage store-data mux.
// Shadows the MEM/WB destination registers and forwards WB results or stalls EXE for one cycle.
module store_data_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exe_valid,
  input  logic                  exe_is_store,
  input  logic [REG_ADDR_W-1:0] exe_rs2,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_reg_write,
  input  logic                  exe_flush,
  input  logic                  ext_stall,
  output logic                  sw_data_sel,
  output logic                  stall_exe,
  output logic [CNT_W-1:0]      fwd_count,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MEM = 0;
  localparam int WB  = 1;

  state_t state_reg, state_next;

  // Shadow stages: index 0 = MEM, index 1 = WB.
  logic [1:0]                 stg_valid_reg, stg_valid_next;
  logic [1:0]                 stg_wr_reg, stg_wr_next;
  logic [1:0][REG_ADDR_W-1:0] stg_rd_reg, stg_rd_next;

  logic [CNT_W-1:0] fwd_count_reg, stall_count_reg;

  logic       store;
  logic [1:0] hit;
  logic       mem_hit, wb_hit;

  assign store = exe_valid & exe_is_store & ~exe_flush;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hit
      assign hit[gi] = store & stg_valid_reg[gi] & stg_wr_reg[gi]
                     & (stg_rd_reg[gi] == exe_rs2) & (exe_rs2 != '0);
    end
  endgenerate

  assign mem_hit = hit[MEM];
  assign wb_hit  = hit[WB];

  // The younger MEM producer takes priority over an older WB match.
  assign stall_exe   = (state_reg == IDLE) & mem_hit;
  assign sw_data_sel = wb_hit & ~mem_hit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (stall_exe) state_next = HOLD;
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stg_valid_next = '0;
    stg_wr_next    = '0;
    stg_rd_next    = '0;
    if (!(stall_exe || exe_flush)) begin
      stg_valid_next[MEM] = exe_valid;
      stg_wr_next[MEM]    = exe_reg_write;
      stg_rd_next[MEM]    = exe_rd;
    end
    stg_valid_next[WB] = stg_valid_reg[MEM];
    stg_wr_next[WB]    = stg_wr_reg[MEM];
    stg_rd_next[WB]    = stg_rd_reg[MEM];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      stg_valid_reg <= '0;
      stg_wr_reg    <= '0;
      stg_rd_reg    <= '0;
    end else if (!ext_stall) begin
      state_reg     <= state_next;
      stg_valid_reg <= stg_valid_next;
      stg_wr_reg    <= stg_wr_next;
      stg_rd_reg    <= stg_rd_next;
    end
  end

  // Saturating debug counters, frozen together with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_count_reg   <= '0;
      stall_count_reg <= '0;
    end else if (!ext_stall) begin
      if (sw_data_sel && (fwd_count_reg != '1))
        fwd_count_reg <= fwd_count_reg + CNT_W'(1);
      if (stall_exe && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + CNT_W'(1);
    end
  end

  assign fwd_count   = fwd_count_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_store_data_fwd_ctrl.sv
// Self-checking bench for store_data_fwd_ctrl: directed scenarios plus random pipeline traffic
// compared against a transaction-level model of the MEM/WB producers.
module tb_store_data_fwd_ctrl;

  localparam int RW      = 5;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exe_valid = 1'b0;
  logic          exe_is_store = 1'b0;
  logic [RW-1:0] exe_rs2 = '0;
  logic [RW-1:0] exe_rd = '0;
  logic          exe_reg_write = 1'b0;
  logic          exe_flush = 1'b0;
  logic          ext_stall = 1'b0;
  logic          sw_data_sel;
  logic          stall_exe;
  logic [CW-1:0] fwd_count;
  logic [CW-1:0] stall_count;

  store_data_fwd_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_is_store(exe_is_store),
    .exe_rs2(exe_rs2), .exe_rd(exe_rd), .exe_reg_write(exe_reg_write),
    .exe_flush(exe_flush), .ext_stall(ext_stall),
    .sw_data_sel(sw_data_sel), .stall_exe(stall_exe),
    .fwd_count(fwd_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: the instructions that left EXE one and two cycles ago,
  // whether the previous advancing cycle issued a stall, and event totals.
  typedef struct {
    bit v;
    int rd;
    bit w;
  } producer_t;

  producer_t m_mem, m_wb;
  bit        m_stalled_last;
  int        m_fwd, m_stall;
  bit        e_sel, e_stall;

  function automatic bit produces(producer_t p, int rs2);
    return p.v && p.w && (p.rd == rs2) && (rs2 != 0);
  endfunction

  task automatic model_reset();
    m_mem = '{0, 0, 0};
    m_wb  = '{0, 0, 0};
    m_stalled_last = 0;
    m_fwd = 0;
    m_stall = 0;
  endtask

  task automatic compute_expected();
    bit st, mh, wh;
    st = exe_valid && exe_is_store && !exe_flush;
    mh = st && produces(m_mem, int'(exe_rs2));
    wh = st && produces(m_wb, int'(exe_rs2));
    // A store that was just stalled sees its producer in WB now; never stall it twice.
    e_stall = mh && !m_stalled_last;
    e_sel   = wh && !mh;
  endtask

  task automatic model_advance();
    if (!ext_stall) begin
      if (e_sel && m_fwd < CNT_MAX) m_fwd++;
      if (e_stall && m_stall < CNT_MAX) m_stall++;
      m_wb = m_mem;
      if (e_stall || exe_flush) m_mem = '{0, 0, 0};
      else m_mem = '{exe_valid, int'(exe_rd), exe_reg_write};
      m_stalled_last = e_stall;
    end
  endtask

  // One pipeline cycle: drive on the falling edge, check, then advance the model.
  task automatic step(input bit v, input bit is_st, input int rs2, input int rd,
                      input bit w, input bit fl, input bit xs, input string tag);
    @(negedge clk);
    exe_valid = v; exe_is_store = is_st; exe_rs2 = RW'(rs2); exe_rd = RW'(rd);
    exe_reg_write = w; exe_flush = fl; ext_stall = xs;
    #1;
    compute_expected();
    check_eq({tag, ".stall"}, int'(stall_exe), int'(e_stall));
    check_eq({tag, ".sel"}, int'(sw_data_sel), int'(e_sel));
    check_eq({tag, ".fcnt"}, int'(fwd_count), m_fwd);
    check_eq({tag, ".scnt"}, int'(stall_count), m_stall);
    $display("step %-8s v=%0d st=%0d rs2=%0d rd=%0d w=%0d fl=%0d xs=%0d -> stall=%0d sel=%0d fcnt=%0d scnt=%0d",
             tag, v, is_st, rs2, rd, w, fl, xs, stall_exe, sw_data_sel, fwd_count, stall_count);
    model_advance();
  endtask

  task automatic nop(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    exe_valid = 0; exe_is_store = 0; exe_flush = 0; ext_stall = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int b_f, b_s;
  bit r_v, r_st, r_w, r_fl, r_xs;
  int r_rs2, r_rd;

  initial begin
    model_reset();
    #1;
    check_eq("rst.stall", int'(stall_exe), 0);
    check_eq("rst.sel", int'(sw_data_sel), 0);
    check_eq("rst.fcnt", int'(fwd_count), 0);
    check_eq("rst.scnt", int'(stall_count), 0);
    apply_reset();

    // 1: back-to-back producer -> one stall, then forward.
    step(1, 0, 0, 5, 1, 0, 0, "t1.add");
    step(1, 1, 5, 0, 0, 0, 0, "t1.sw");
    step(1, 1, 5, 0, 0, 0, 0, "t1.sw2");
    nop("t1.nop");
    check_eq("t1.scnt1", int'(stall_count), 1);
    check_eq("t1.fcnt1", int'(fwd_count), 1);

    // 2: producer two ahead -> forward without stall.
    step(1, 0, 0, 7, 1, 0, 0, "t2.add");
    step(1, 0, 0, 9, 0, 0, 0, "t2.oth");
    step(1, 1, 7, 0, 0, 0, 0, "t2.sw");
    nop("t2.nop");

    // 3: rd=3 in both MEM and WB -> MEM wins.
    step(1, 0, 0, 3, 1, 0, 0, "t3.p1");
    step(1, 0, 0, 3, 1, 0, 0, "t3.p2");
    step(1, 1, 3, 0, 0, 0, 0, "t3.sw");
    step(1, 1, 3, 0, 0, 0, 0, "t3.sw2");
    nop("t3.nop");

    // 4: x0 never matches.
    step(1, 0, 0, 0, 1, 0, 0, "t4.add");
    step(1, 1, 0, 0, 0, 0, 0, "t4.sw");
    step(1, 1, 0, 0, 0, 0, 0, "t4.sw2");

    // 5: MEM-hit store frozen by ext_stall for 3 cycles.
    step(1, 0, 0, 6, 1, 0, 0, "t5.add");
    b_f = m_fwd; b_s = m_stall;
    for (int i = 0; i < 3; i++) step(1, 1, 6, 0, 0, 0, 1, "t5.frz");
    check_eq("t5.frzcnt", int'(stall_count), b_s);
    step(1, 1, 6, 0, 0, 0, 0, "t5.rel");
    step(1, 1, 6, 0, 0, 0, 0, "t5.fwd");
    nop("t5.nop");
    check_eq("t5.scnt", int'(stall_count), b_s + 1);
    check_eq("t5.fcnt", int'(fwd_count), b_f + 1);

    // Flush alongside a hit: no stall, no select, bubble into MEM.
    step(1, 0, 0, 4, 1, 0, 0, "fl.add");
    step(1, 1, 4, 0, 0, 1, 0, "fl.sw");
    step(1, 1, 4, 0, 0, 0, 0, "fl.sw2");
    nop("fl.nop");

    // 6: asynchronous reset while in HOLD.
    step(1, 0, 0, 5, 1, 0, 0, "t6.add");
    step(1, 1, 5, 0, 0, 0, 0, "t6.sw");
    @(posedge clk);
    #2;
    compute_expected();
    check_eq("t6.holdsel", int'(sw_data_sel), int'(e_sel));
    rst = 1'b1;
    #1;
    check_eq("t6.rstsel", int'(sw_data_sel), 0);
    check_eq("t6.rststall", int'(stall_exe), 0);
    check_eq("t6.rstfcnt", int'(fwd_count), 0);
    check_eq("t6.rstscnt", int'(stall_count), 0);
    $display("t6 reset during HOLD: sel=%0d stall=%0d fcnt=%0d scnt=%0d",
             sw_data_sel, stall_exe, fwd_count, stall_count);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 5, 0, 0, 0, 0, "t6.sw");
    check_eq("t6.nofwd", int'(sw_data_sel), 0);

    // Random traffic; a stalled store is re-presented as the real pipeline would.
    r_v = 0; r_st = 0; r_rs2 = 0; r_rd = 0; r_w = 0;
    for (int i = 0; i < 600; i++) begin
      r_xs = ($urandom_range(0, 99) < 12);
      if (!(e_stall && !ext_stall && i > 0)) begin
        r_v   = ($urandom_range(0, 99) < 85);
        r_st  = ($urandom_range(0, 99) < 50);
        r_rs2 = $urandom_range(0, 3);
        r_rd  = $urandom_range(0, 3);
        r_w   = ($urandom_range(0, 99) < 70);
      end
      r_fl = ($urandom_range(0, 99) < 8);
      step(r_v, r_st, r_rs2, r_rd, r_w, r_fl, r_xs, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
